// File: rtl/usb_token_decoder_pkg.sv
// Shared USB receive-side types: PID encodings, token record, decoder FSM
// states, and CRC5 helpers.
//   pid_t        4-bit USB packet identifier
//   token_t      {pid, addr, endp, crc5} of a token packet
//   tok_state_t  token decoder FSM states
//   crc5_upd     8-bit parallel CRC5 update, bit 0 of data first
package types;

  typedef enum logic [3:0] {
    PID_RESERVED = 4'h0, PID_OUT     = 4'h1, PID_ACK   = 4'h2, PID_DATA0 = 4'h3,
    PID_PING     = 4'h4, PID_SOF     = 4'h5, PID_NYET  = 4'h6, PID_DATA2 = 4'h7,
    PID_SPLIT    = 4'h8, PID_IN      = 4'h9, PID_NAK   = 4'hA, PID_DATA1 = 4'hB,
    PID_PRE_ERR  = 4'hC, PID_SETUP   = 4'hD, PID_STALL = 4'hE, PID_MDATA = 4'hF
  } pid_t;

  typedef struct packed {
    pid_t       pid;
    logic [6:0] addr;
    logic [3:0] endp;
    logic [4:0] crc5;
  } token_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PID, ST_TOK1, ST_TOK2, ST_TOKEND, ST_CHECK, ST_HS, ST_DRAIN
  } tok_state_t;

  localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;

  // Polynomial x^5+x^2+1, register MSB is the feedback tap.
  function automatic logic [4:0] crc5_upd(logic [4:0] c, logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[4] ^ d[i]) r = {r[3:0], 1'b0} ^ 5'b00101;
      else             r = {r[3:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic is_token(pid_t p);
    return (p == PID_OUT) || (p == PID_IN) || (p == PID_SOF) || (p == PID_SETUP);
  endfunction

  function automatic logic is_data(pid_t p);
    return (p == PID_DATA0) || (p == PID_DATA1) || (p == PID_DATA2) || (p == PID_MDATA);
  endfunction

  function automatic logic is_handshake(pid_t p);
    return (p == PID_ACK) || (p == PID_NAK) || (p == PID_STALL) || (p == PID_NYET);
  endfunction

endpackage

// File: rtl/usb_token_decoder_crc5.sv
// USB CRC5 accumulator.
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        preset the register to all ones (start of packet)
//   en           fold data into the register
//   data         byte, bit 0 first on the wire
//   residual_ok  register holds the good-packet residual
module usb_crc5
  import types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] data,
  output logic       residual_ok
);

  logic [4:0] crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     crc <= '1;
    else if (clear) crc <= '1;
    else if (en)    crc <= crc5_upd(crc, data);
  end

  assign residual_ok = (crc == CRC5_RESIDUAL);

endmodule

// File: rtl/usb_token_decoder.sv
// USB receive packet classifier: decodes the PID byte, assembles tokens,
// checks PID complement and CRC5, reports handshakes and data packet starts.
//   rx_active/rx_valid/rx_data/rx_error  byte stream from the receive path
//   dev_addr                             address this device answers to
//   token_valid, token, frame_no         good token (SOF: any address)
//   hs_valid, data_start                 handshake / data packet notification
//   pid                                  PID of current/last packet
//   pid_err, crc5_err, len_err           one-cycle error pulses
module usb_token_decoder
  import types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_active,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_error,
  input  logic [6:0]  dev_addr,
  output logic        token_valid,
  output token_t      token,
  output logic [10:0] frame_no,
  output logic        hs_valid,
  output logic        data_start,
  output pid_t        pid,
  output logic        pid_err,
  output logic        crc5_err,
  output logic        len_err
);

  tok_state_t state;
  logic [3:0] pidx_q;
  token_t     tok_q;
  logic       crc_clear, crc_en, crc_ok;
  logic       abort, pid_ok;

  assign abort  = rx_error && rx_active;
  assign pid_ok = (pidx_q == ~pid);

  always_comb begin
    crc_clear = (state == ST_IDLE) && rx_valid && rx_active;
    crc_en    = rx_valid && !abort &&
                ((state == ST_TOK1) || (state == ST_TOK2) ||
                 ((state == ST_PID) && pid_ok && is_token(pid)));
  end

  usb_crc5 u_crc5 (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (crc_clear),
    .en          (crc_en),
    .data        (rx_data),
    .residual_ok (crc_ok)
  );

  // Every end-of-packet verdict goes through CHECK so that token, handshake
  // and CRC results share the same latency from the rx_active fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pidx_q      <= '0;
      tok_q       <= '0;
      token       <= '0;
      frame_no    <= '0;
      pid         <= PID_RESERVED;
      token_valid <= 1'b0;
      hs_valid    <= 1'b0;
      data_start  <= 1'b0;
      pid_err     <= 1'b0;
      crc5_err    <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      token_valid <= 1'b0;
      hs_valid    <= 1'b0;
      data_start  <= 1'b0;
      pid_err     <= 1'b0;
      crc5_err    <= 1'b0;
      len_err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_valid && rx_active) begin
            if (rx_error) begin
              state <= ST_DRAIN;
            end else begin
              pid    <= pid_t'(rx_data[3:0]);
              pidx_q <= rx_data[7:4];
              state  <= ST_PID;
            end
          end
        end
        ST_PID: begin
          if (abort) begin
            state <= ST_DRAIN;
          end else if (!pid_ok) begin
            pid_err <= 1'b1;
            state   <= ST_DRAIN;
          end else if (is_data(pid)) begin
            data_start <= 1'b1;
            state      <= ST_DRAIN;
          end else if (is_handshake(pid)) begin
            if (rx_valid) begin
              len_err <= 1'b1;
              state   <= ST_DRAIN;
            end else if (!rx_active) begin
              state <= ST_CHECK;
            end else begin
              state <= ST_HS;
            end
          end else if (is_token(pid)) begin
            tok_q.pid <= pid;
            // A back-to-back byte 1 is taken here rather than lost.
            if (rx_valid) begin
              tok_q.addr    <= rx_data[6:0];
              tok_q.endp[0] <= rx_data[7];
              state         <= ST_TOK2;
            end else if (!rx_active) begin
              len_err <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              state <= ST_TOK1;
            end
          end else begin
            state <= ST_DRAIN;
          end
        end
        ST_TOK1: begin
          if (abort) begin
            state <= ST_DRAIN;
          end else if (rx_valid) begin
            tok_q.addr    <= rx_data[6:0];
            tok_q.endp[0] <= rx_data[7];
            state         <= ST_TOK2;
          end else if (!rx_active) begin
            len_err <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        ST_TOK2: begin
          if (abort) begin
            state <= ST_DRAIN;
          end else if (rx_valid) begin
            tok_q.endp[3:1] <= rx_data[2:0];
            tok_q.crc5      <= rx_data[7:3];
            state           <= rx_active ? ST_TOKEND : ST_CHECK;
          end else if (!rx_active) begin
            len_err <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        ST_TOKEND, ST_HS: begin
          if (abort) begin
            state <= ST_DRAIN;
          end else if (rx_valid) begin
            len_err <= 1'b1;
            state   <= ST_DRAIN;
          end else if (!rx_active) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (is_handshake(pid)) begin
            hs_valid <= 1'b1;
          end else if (!crc_ok) begin
            crc5_err <= 1'b1;
          end else if (tok_q.pid == PID_SOF) begin
            frame_no    <= {tok_q.endp, tok_q.addr};
            token       <= tok_q;
            token_valid <= 1'b1;
          end else if (tok_q.addr == dev_addr) begin
            token       <= tok_q;
            token_valid <= 1'b1;
          end
          state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (!rx_active) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
